// File: rtl/adc_capture_sequencer.sv
// ADC capture-buffer sequencer: arm, pre-trigger fill, slope/level trigger,
// post-trigger fill, then hold the buffer until the display has drawn it.
module adc_capture_sequencer #(
  parameter int unsigned ADDR_W       = 11,
  parameter int unsigned DATA_W       = 8,
  parameter logic [19:0] AUTO_TIMEOUT = 20'd65535
) (
  input  logic              CLK_64MHZ,
  input  logic              MASTER_RST_N,
  input  logic              SAMPLE_EN,
  input  logic [DATA_W-1:0] SAMPLE_DATA,
  input  logic [DATA_W-1:0] TRIG_LEVEL,
  input  logic              TRIG_SLOPE,
  input  logic [1:0]        TRIG_MODE,
  input  logic              ARM,
  input  logic [ADDR_W-1:0] PRE_COUNT,
  input  logic              DISPLAY_DONE,
  output logic              WR_EN,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic [DATA_W-1:0] WR_DATA,
  output logic [ADDR_W-1:0] TRIG_ADDR,
  output logic              CAPTURE_READY,
  output logic              FORCED,
  output logic [2:0]        STATE
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned TMO_W = 20;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'((2 ** ADDR_W) - 1);
  localparam logic [1:0] MODE_AUTO = 2'b01;
  localparam logic [1:0] MODE_STOP = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PREFILL  = 3'd1,
    S_WAIT     = 3'd2,
    S_POSTFILL = 3'd3,
    S_HOLD     = 3'd4
  } state_t;

  state_t              r_state, w_state_nxt;
  logic                r_wr_en, r_ready, r_forced, r_prev_valid, r_slope;
  logic [ADDR_W-1:0]   r_wr_addr, r_next_addr, r_trig_addr, r_pre;
  logic [DATA_W-1:0]   r_wr_data, r_prev, r_level;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt, w_cnt_inc, w_post_len;
  logic [TMO_W-1:0]    r_tmo, w_tmo_nxt, w_tmo_inc;
  logic                w_capturing, w_wr, w_rise, w_fall, w_hit;
  logic                w_load, w_take, w_force;

  assign w_capturing = (r_state == S_PREFILL) || (r_state == S_WAIT) || (r_state == S_POSTFILL);
  assign w_wr        = SAMPLE_EN && w_capturing;
  assign w_rise      = r_prev_valid && (r_prev < r_level) && (SAMPLE_DATA >= r_level);
  assign w_fall      = r_prev_valid && (r_prev >= r_level) && (SAMPLE_DATA < r_level);
  assign w_hit       = r_slope ? w_fall : w_rise;
  assign w_cnt_inc   = r_cnt + CNT_W'(1);
  assign w_tmo_inc   = r_tmo + TMO_W'(1);
  assign w_post_len  = LAST_IDX - CNT_W'(r_pre);

  always_ff @(posedge CLK_64MHZ or negedge MASTER_RST_N) begin
    if (!MASTER_RST_N) r_state <= S_IDLE;
    else               r_state <= w_state_nxt;
  end

  // Next-state and control strobes; ARM/re-arm read the live settings, captures use latched ones.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_tmo_nxt   = r_tmo;
    w_load      = 1'b0;
    w_take      = 1'b0;
    w_force     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (ARM && (TRIG_MODE != MODE_STOP)) begin
          w_load      = 1'b1;
          w_cnt_nxt   = '0;
          w_tmo_nxt   = '0;
          w_state_nxt = (PRE_COUNT == '0) ? S_WAIT : S_PREFILL;
        end
      end
      S_PREFILL: begin
        if (TRIG_MODE == MODE_STOP) begin
          w_state_nxt = S_IDLE;
        end else if (SAMPLE_EN) begin
          if (w_cnt_inc == CNT_W'(r_pre)) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_WAIT;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
      end
      S_WAIT: begin
        if (TRIG_MODE == MODE_STOP) begin
          w_state_nxt = S_IDLE;
        end else if (SAMPLE_EN) begin
          if (w_hit) begin
            w_take = 1'b1;
          end else if ((TRIG_MODE == MODE_AUTO) && (w_tmo_inc == AUTO_TIMEOUT)) begin
            w_take  = 1'b1;
            w_force = 1'b1;
          end else begin
            w_tmo_nxt = w_tmo_inc;
          end
          if (w_take) begin
            w_cnt_nxt   = '0;
            w_tmo_nxt   = '0;
            w_state_nxt = (w_post_len == '0) ? S_HOLD : S_POSTFILL;
          end
        end
      end
      S_POSTFILL: begin
        if (SAMPLE_EN) begin
          if (w_cnt_inc == w_post_len) w_state_nxt = S_HOLD;
          else                         w_cnt_nxt   = w_cnt_inc;
        end
      end
      S_HOLD: begin
        if (DISPLAY_DONE) begin
          if (TRIG_MODE[1]) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_load      = 1'b1;
            w_cnt_nxt   = '0;
            w_tmo_nxt   = '0;
            w_state_nxt = (PRE_COUNT == '0) ? S_WAIT : S_PREFILL;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Buffer write port, trigger bookkeeping and latched capture settings.
  always_ff @(posedge CLK_64MHZ or negedge MASTER_RST_N) begin
    if (!MASTER_RST_N) begin
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_next_addr  <= '0;
      r_wr_data    <= '0;
      r_trig_addr  <= '0;
      r_ready      <= 1'b0;
      r_forced     <= 1'b0;
      r_prev       <= '0;
      r_prev_valid <= 1'b0;
      r_pre        <= '0;
      r_level      <= '0;
      r_slope      <= 1'b0;
      r_cnt        <= '0;
      r_tmo        <= '0;
    end else begin
      r_wr_en <= w_wr;
      r_cnt   <= w_cnt_nxt;
      r_tmo   <= w_tmo_nxt;
      r_ready <= (w_state_nxt == S_HOLD);
      if (w_wr) begin
        r_wr_addr    <= r_next_addr;
        r_wr_data    <= SAMPLE_DATA;
        r_next_addr  <= r_next_addr + ADDR_W'(1);
        r_prev       <= SAMPLE_DATA;
        r_prev_valid <= 1'b1;
      end
      if (w_load) begin
        r_pre        <= PRE_COUNT;
        r_level      <= TRIG_LEVEL;
        r_slope      <= TRIG_SLOPE;
        r_forced     <= 1'b0;
        r_prev_valid <= 1'b0;
      end
      if (w_take)  r_trig_addr <= r_next_addr;
      if (w_force) r_forced    <= 1'b1;
    end
  end

  assign WR_EN         = r_wr_en;
  assign WR_ADDR       = r_wr_addr;
  assign WR_DATA       = r_wr_data;
  assign TRIG_ADDR     = r_trig_addr;
  assign CAPTURE_READY = r_ready;
  assign FORCED        = r_forced;
  assign STATE         = r_state;

endmodule

// File: tb/tb_adc_capture_sequencer.sv
// Self-checking bench for adc_capture_sequencer: scoreboarded write port plus
// a trigger vector table and hand sequences for the multi-cycle corners.
module tb_adc_capture_sequencer;

  localparam int unsigned AW = 11;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          sample_en, trig_slope, arm_i, display_done;
  logic [DW-1:0] sample_data, trig_level;
  logic [1:0]    trig_mode;
  logic [AW-1:0] pre_count;
  logic          wr_en, capture_ready, forced;
  logic [AW-1:0] wr_addr, trig_addr;
  logic [DW-1:0] wr_data;
  logic [2:0]    state;

  adc_capture_sequencer #(.ADDR_W(AW), .DATA_W(DW), .AUTO_TIMEOUT(20'd16)) dut (
    .CLK_64MHZ    (clk),
    .MASTER_RST_N (rst_n),
    .SAMPLE_EN    (sample_en),
    .SAMPLE_DATA  (sample_data),
    .TRIG_LEVEL   (trig_level),
    .TRIG_SLOPE   (trig_slope),
    .TRIG_MODE    (trig_mode),
    .ARM          (arm_i),
    .PRE_COUNT    (pre_count),
    .DISPLAY_DONE (display_done),
    .WR_EN        (wr_en),
    .WR_ADDR      (wr_addr),
    .WR_DATA      (wr_data),
    .TRIG_ADDR    (trig_addr),
    .CAPTURE_READY(capture_ready),
    .FORCED       (forced),
    .STATE        (state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct {
    logic          slope;
    logic [DW-1:0] level;
    logic [DW-1:0] prev;
    logic [DW-1:0] cur;
    logic          hit;
  } trig_vec_t;

  wr_t           sb_q[$];
  wr_t           mon_exp;
  trig_vec_t     vecs[8];
  int            n_checks = 0;
  int            n_errors = 0;
  logic          m_capt = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [AW-1:0] ta;
  logic [AW-1:0] gap;
  int            n;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every observed write must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && wr_en) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_errors++;
        $display("FAIL wr_unexpected: write addr %0d data %0h, expected no write", wr_addr, wr_data);
      end else begin
        mon_exp = sb_q.pop_front();
        if (wr_addr !== mon_exp.addr || wr_data !== mon_exp.data) begin
          n_errors++;
          $display("FAIL wr_port: got addr %0d data %0h expected addr %0d data %0h",
                   wr_addr, wr_data, mon_exp.addr, mon_exp.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic arm(input logic [AW-1:0] pre, input logic [DW-1:0] lvl,
                     input logic slope, input logic [1:0] mode);
    trig_mode  = mode;
    pre_count  = pre;
    trig_level = lvl;
    trig_slope = slope;
    arm_i      = 1'b1;
    tick();
    arm_i  = 1'b0;
    m_capt = 1'b1;
  endtask

  task automatic send(input logic [DW-1:0] d);
    sample_en   = 1'b1;
    sample_data = d;
    if (m_capt) begin
      sb_q.push_back({m_addr, d});
      m_addr = m_addr + AW'(1);
    end
    tick();
    sample_en = 1'b0;
  endtask

  task automatic fill(input int cnt, input logic [DW-1:0] d);
    for (int i = 0; i < cnt; i++) send(d);
  endtask

  task automatic stop_now();
    trig_mode = 2'b11;
    tick();
    m_capt = 1'b0;
  endtask

  task automatic done_pulse(input logic [1:0] mode);
    trig_mode    = mode;
    display_done = 1'b1;
    tick();
    display_done = 1'b0;
  endtask

  initial begin
    vecs[0] = '{1'b0, 8'h80, 8'h7F, 8'h80, 1'b1};
    vecs[1] = '{1'b0, 8'h80, 8'h80, 8'h81, 1'b0};
    vecs[2] = '{1'b0, 8'h80, 8'h00, 8'h7F, 1'b0};
    vecs[3] = '{1'b0, 8'h80, 8'h7F, 8'hFF, 1'b1};
    vecs[4] = '{1'b1, 8'h40, 8'h90, 8'h30, 1'b1};
    vecs[5] = '{1'b1, 8'h40, 8'h40, 8'h3F, 1'b1};
    vecs[6] = '{1'b1, 8'h40, 8'h41, 8'h40, 1'b0};
    vecs[7] = '{1'b1, 8'h40, 8'h30, 8'h30, 1'b0};

    rst_n = 1'b0; sample_en = 1'b0; sample_data = '0; trig_level = '0; trig_slope = 1'b0;
    trig_mode = 2'b00; arm_i = 1'b0; pre_count = '0; display_done = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_trig_addr", trig_addr, 0);
    chk("rst_ready", capture_ready, 0);
    chk("rst_forced", forced, 0);
    chk("rst_state", state, 0);

    // Ramp from 0x80 so the first post-prefill sample crosses the level.
    arm(AW'(1024), 8'h80, 1'b0, 2'b00);
    chk("t1_prefill", state, 1);
    for (int i = 0; i < 1024; i++) send(DW'(8'h80 + i));
    chk("t1_wait", state, 2);
    send(8'h80);
    chk("t1_post", state, 3);
    chk("t1_trig_addr", trig_addr, 1024);
    for (int i = 1; i < 1023; i++) send(DW'(8'h80 + i));
    chk("t1_not_ready", capture_ready, 0);
    send(8'hFF);
    m_capt = 1'b0;
    chk("t1_ready", capture_ready, 1);
    chk("t1_hold", state, 4);
    chk("t1_forced", forced, 0);
    send(8'h11);
    chk("t1_hold_no_write", wr_en, 0);
    sample_en = 1'b1; sample_data = 8'hAA;
    done_pulse(2'b00);
    sample_en = 1'b0;
    chk("t5_done_drop", wr_en, 0);
    chk("t5_rearm_prefill", state, 1);
    chk("t5_ready_clr", capture_ready, 0);
    m_capt = 1'b1;
    stop_now();
    chk("t6_stop_prefill", state, 0);
    chk("t6_stop_ready", capture_ready, 0);

    for (int v = 0; v < 8; v++) begin
      arm('0, vecs[v].level, vecs[v].slope, 2'b00);
      chk($sformatf("vec%0d_direct_wait", v), state, 2);
      send(vecs[v].prev);
      chk($sformatf("vec%0d_first_no_trig", v), state, 2);
      ta = m_addr;
      send(vecs[v].cur);
      chk($sformatf("vec%0d_hit", v), state, vecs[v].hit ? 3 : 2);
      if (vecs[v].hit) begin
        chk($sformatf("vec%0d_trig_addr", v), trig_addr, ta);
        fill(2047, vecs[v].cur);
        m_capt = 1'b0;
        chk($sformatf("vec%0d_ready", v), capture_ready, 1);
        done_pulse(2'b10);
        chk($sformatf("vec%0d_single_idle", v), state, 0);
      end else begin
        stop_now();
      end
    end

    arm('0, 8'h80, 1'b0, 2'b01);
    fill(15, 8'h10);
    chk("t3_auto_waiting", state, 2);
    ta = m_addr;
    send(8'h10);
    chk("t3_forced_post", state, 3);
    chk("t3_forced_flag", forced, 1);
    chk("t3_forced_addr", trig_addr, ta);
    fill(2047, 8'h10);
    m_capt = 1'b0;
    chk("t3_ready", capture_ready, 1);
    chk("t3_forced_hold", forced, 1);
    done_pulse(2'b10);
    arm('0, 8'h80, 1'b0, 2'b00);
    chk("t3_forced_cleared", forced, 0);
    fill(40, 8'h10);
    chk("t3_normal_no_force", state, 2);
    stop_now();

    // Walk the write pointer to 2040 using aborted prefills.
    while (m_addr != AW'(2040)) begin
      gap = AW'(2040) - m_addr;
      n = int'(gap);
      if (n > 2000) n = 2000;
      arm(AW'(2047), 8'h80, 1'b0, 2'b00);
      fill(n, 8'h00);
      stop_now();
    end
    arm('0, 8'h80, 1'b0, 2'b00);
    chk("t4_direct_wait", state, 2);
    fill(8, 8'h00);
    chk("t4_addr_2047", wr_addr, 2047);
    send(8'h00);
    chk("t4_addr_wrap", wr_addr, 0);
    send(8'h00);
    send(8'hFF);
    chk("t4_trig_post", state, 3);
    chk("t4_trig_addr", trig_addr, 2);
    fill(2047, 8'h00);
    m_capt = 1'b0;
    chk("t4_ready", capture_ready, 1);
    done_pulse(2'b10);
    arm(AW'(2047), 8'h80, 1'b0, 2'b00);
    fill(2047, 8'h00);
    chk("t4_full_pre_wait", state, 2);
    ta = m_addr;
    send(8'h90);
    m_capt = 1'b0;
    chk("t4_trig_to_hold", state, 4);
    chk("t4_trig_ready", capture_ready, 1);
    chk("t4_full_pre_addr", trig_addr, ta);

    pre_count = '0;
    done_pulse(2'b00);
    m_capt = 1'b1;
    chk("t5_rearm_wait", state, 2);
    send(8'h00);
    send(8'hFF);
    chk("t5_post", state, 3);
    pre_count = AW'(5);
    arm_i = 1'b1;
    tick();
    arm_i = 1'b0;
    chk("t5_arm_ignored", state, 3);
    fill(100, 8'h55);
    chk("t5_still_post", state, 3);

    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    m_capt = 1'b0;
    m_addr = '0;
    chk("t6_rst_wr_en", wr_en, 0);
    chk("t6_rst_wr_addr", wr_addr, 0);
    chk("t6_rst_wr_data", wr_data, 0);
    chk("t6_rst_trig_addr", trig_addr, 0);
    chk("t6_rst_ready", capture_ready, 0);
    chk("t6_rst_forced", forced, 0);
    chk("t6_rst_state", state, 0);
    chk("t6_rst_sb_drained", sb_q.size(), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    arm('0, 8'h80, 1'b0, 2'b00);
    fill(3, 8'h00);
    chk("t6_wait", state, 2);
    stop_now();
    chk("t6_stop_wait_idle", state, 0);
    chk("t6_stop_wait_ready", capture_ready, 0);
    repeat (2) tick();
    chk("final_sb_empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
